ay_envgen: RTL and testbench
============================

Name: ay_envgen

Overview:
- Envelope generator for the AY-3-8910 rendering path.
- Produces the 4-bit envelope level that feeds the volume-to-amplitude lookup stage whenever a channel's envelope-mode bit is set.
- Implements the period prescaler, the period counter, the 16-step ramp and the shape state machine (CONT/ATT/ALT/HOLD).
- Register-file writes arrive as decoded values plus a shape-write strobe.

Parameters:
- PRESCALE, 256, number of ce ticks per period-counter increment; AY rate is f_ce/(256*EP); must be >=2; benches use 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- ce  in  1  chip-clock enable, one clk-cycle pulse per AY master clock.
- period  in  16  envelope period EP from R11/R12; sampled continuously.
- shape  in  4  envelope shape: [3]CONT [2]ATT [1]ALT [0]HOLD; captured on shape_wr.
- shape_wr  in  1  one-cycle strobe: shape register written; restarts the envelope.
- level  out  4  current envelope level, 0..15.
- step  out  1  one-cycle pulse on every ramp-step advance.
- holding  out  1  1 while the envelope is frozen at a final level.

Behaviour:
- State registers:
  - presc: counts 0..PRESCALE-1.
  - pcnt: 16-bit period counter.
  - cnt: 4-bit step counter.
  - dir: 1 = rising, 0 = falling.
  - hold_r: hold flag.
  - hlev: 4-bit held level.
  - shp: 4-bit captured shape.
- Reset (async, rst_n=0):
  - presc=0, pcnt=0, cnt=0, dir=0, shp=0, hold_r=1, hlev=0.
  - Outputs: level=0, step=0, holding=1.
- Level decode is combinational from registers, so there is no added latency:
  - hold_r=1: level=hlev.
  - dir=1: level=cnt.
  - dir=0: level=15-cnt.
- Prescaler:
  - On ce: presc increments, wrapping at PRESCALE-1.
  - The wrap cycle produces an internal tick.
- Period counter:
  - Effective period EPe = (period==0) ? 1 : period.
  - On tick: if pcnt >= EPe-1, pcnt<=0 and a step event fires; else pcnt<=pcnt+1.
  - The >= compare makes a period shrink below pcnt fire on the next tick.
  - Period changes never reset pcnt.
- Step event with hold_r=0:
  - step=1 for exactly that clk cycle.
  - If cnt<15: cnt<=cnt+1.
  - If cnt==15 (end of cycle):
    - CONT=0: hold_r<=1, hlev<=0.
    - CONT=1, HOLD=1: hold_r<=1, hlev <= (ATT^ALT) ? 15 : 0.
    - CONT=1, HOLD=0: cnt<=0; if ALT, dir<=~dir.
- Step event with hold_r=1:
  - pcnt keeps running.
  - cnt, dir and hlev are frozen.
  - step still pulses.
- shape_wr restart, on the next clk edge:
  - shp<=shape, presc<=0, pcnt<=0, cnt<=0, dir<=shape[2], hold_r<=0, step=0.
  - level becomes shape[2] ? 0 : 15 in the cycle after the strobe.
- Simultaneous events:
  - shape_wr in the same cycle as ce or a step event: restart wins, and that tick/step is discarded.
  - shape_wr held high for N cycles restarts on each cycle, so the envelope is frozen at its start level.
- Reset mid-ramp: immediate return to the reset state; the envelope stays held at 0 until the next shape_wr.
- step and holding are registered outputs.

Test Plan:
- Reset with PRESCALE=4, then release with no writes -> level=0, holding=1, step pulses every 4*EPe ce ticks (EP=1: every 4 ce), level stays 0.
- Shape 0x0, EP=1, ce every cycle:
  - level 15 after strobe, then decrements by 1 every 4 cycles: 15,14..0.
  - After the 16th step: holding=1, level=0, permanently.
- Shape 0xD (attack, hold), EP=2:
  - level 0,1..15, each value lasting 8 ce ticks.
  - After the cnt==15 step: holding=1, level=15 held.
- Shape 0xE (ALT, CONT), EP=1:
  - triangle 0..15,15..0,0..15.
  - Endpoints repeat once at each reversal.
  - holding stays 0 for 100 steps.
- Shape 0x8 with EP=0 vs EP=1 -> identical step spacing (4 ce). Period changed 100->3 while pcnt=50 -> step on the next tick, then every 3 ticks.
- shape_wr coincident with a step event mid-ramp (cnt=7) -> no step pulse that cycle, cnt=0, level per new ATT; async rst_n low mid-ramp -> level=0, holding=1 without a clk edge.

Source files
------------

// File: rtl/ay_env_if.sv
// AY envelope generator register-side bundle.
// Decoded period/shape in, envelope level and status out.
interface ay_env_if;
  logic        ce;
  logic [15:0] period;
  logic [3:0]  shape;
  logic        shape_wr;
  logic [3:0]  level;
  logic        step;
  logic        holding;

  modport master (
    output ce, period, shape, shape_wr,
    input  level, step, holding
  );

  modport slave (
    input  ce, period, shape, shape_wr,
    output level, step, holding
  );
endinterface

// File: rtl/ay_envgen.sv
// AY-3-8910 envelope generator: prescaler, period counter,
// 16-step ramp and CONT/ATT/ALT/HOLD shape sequencer.
module ay_envgen #(
  parameter int PRESCALE = 256
) (
  input logic   clk,
  input logic   rst_n,
  ay_env_if.slave bus
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RISE,
    S_FALL
  } st_t;

  st_t           st, st_n;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    hlev, hlev_n;
  logic [3:0]    shp;
  logic [PW-1:0] presc;
  logic [15:0]   pcnt;
  logic [15:0]   epe;
  logic          step_r;
  logic          tick;
  logic          pwrap;
  logic          stev;
  logic          eoc;
  logic [3:0]    level;

  assign tick  = bus.ce && (presc == PW'(PRESCALE - 1));
  assign epe   = (bus.period == 16'd0) ? 16'd1 : bus.period;
  // >= so a period shrunk below pcnt fires on the next tick
  assign pwrap = pcnt >= (epe - 16'd1);
  assign stev  = tick && pwrap;
  assign eoc   = cnt == 4'hf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      pcnt   <= '0;
      shp    <= '0;
      step_r <= 1'b0;
    end else if (bus.shape_wr) begin
      presc  <= '0;
      pcnt   <= '0;
      shp    <= bus.shape;
      step_r <= 1'b0;
    end else begin
      step_r <= stev;
      if (bus.ce)
        presc <= tick ? '0 : presc + PW'(1);
      if (tick)
        pcnt <= pwrap ? '0 : pcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_HOLD;
      cnt  <= '0;
      hlev <= '0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      hlev <= hlev_n;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    hlev_n = hlev;
    if (bus.shape_wr) begin
      st_n  = bus.shape[2] ? S_RISE : S_FALL;
      cnt_n = '0;
    end else if (stev && st != S_HOLD) begin
      unique case (1'b1)
        !eoc: cnt_n = cnt + 4'd1;
        eoc && !shp[3]: begin
          st_n   = S_HOLD;
          hlev_n = 4'h0;
        end
        eoc && shp[3] && shp[0]: begin
          st_n   = S_HOLD;
          hlev_n = (shp[2] ^ shp[1]) ? 4'hf : 4'h0;
        end
        eoc && shp[3] && !shp[0]: begin
          cnt_n = '0;
          if (shp[1])
            st_n = (st == S_RISE) ? S_FALL : S_RISE;
        end
      endcase
    end
  end

  always_comb begin
    level = ~cnt;
    case (st)
      S_HOLD:  level = hlev;
      S_RISE:  level = cnt;
      default: level = ~cnt;
    endcase
  end

  assign bus.level   = level;
  assign bus.step    = step_r;
  assign bus.holding = (st == S_HOLD);

endmodule

// File: tb/tb_ay_envgen.sv
// Scoreboard bench for ay_envgen with PRESCALE=4:
// expected step responses queued by stimulus, checked by a monitor.
module tb_ay_envgen;

  typedef struct {
    string    nm;
    logic [3:0] lvl;
    logic     hld;
    int       gap;
  } exp_t;

  logic clk;
  logic rst_n;
  logic armed;
  logic ce_half;
  int   vectors;
  int   errs;
  int   gap;
  exp_t sb[$];

  ay_env_if bus ();

  ay_envgen #(.PRESCALE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bus.ce = ce_half ? ~bus.ce : 1'b1;
  end

  function automatic void push(string nm, int l, bit h, int g);
    exp_t e;
    e.nm  = nm;
    e.lvl = 4'(l);
    e.hld = h;
    e.gap = g;
    sb.push_back(e);
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every step pulse is one observed response
  always @(negedge clk) begin
    exp_t e;
    gap++;
    if (bus.shape_wr) begin
      gap = 0;
    end else if (bus.step) begin
      if (armed) begin
        vectors++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL unexpected_step: level %0d gap %0d",
                   bus.level, gap);
        end else begin
          e = sb.pop_front();
          if (bus.level !== e.lvl || bus.holding !== e.hld ||
              (e.gap >= 0 && gap != e.gap)) begin
            errs++;
            $display({"FAIL %s: level %0d hold %0b gap %0d,",
                      " expected level %0d hold %0b gap %0d"},
                     e.nm, bus.level, bus.holding, gap,
                     e.lvl, e.hld, e.gap);
          end
        end
      end
      gap = 0;
    end
  end

  task automatic drain(string nm, int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL %s_timeout: %0d pending expected 0",
               nm, sb.size());
      sb.delete();
    end
    armed = 1'b0;
  endtask

  task automatic wr(input logic [3:0] s);
    @(posedge clk);
    #1;
    bus.shape    = s;
    bus.shape_wr = 1'b1;
    armed        = 1'b1;
    @(posedge clk);
    #1;
    bus.shape_wr = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    errs         = 0;
    gap          = 0;
    armed        = 1'b0;
    ce_half      = 1'b0;
    rst_n        = 1'b0;
    bus.ce       = 1'b0;
    bus.period   = 16'd1;
    bus.shape    = 4'h0;
    bus.shape_wr = 1'b0;

    // reset state, then free run while held at 0
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 8'(bus.level), 8'd0);
    chk("rst_holding", 8'(bus.holding), 8'd1);
    chk("rst_step", 8'(bus.step), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("idle_step", 0, 1, -1);
    push("idle_step", 0, 1, 4);
    push("idle_step", 0, 1, 4);
    armed = 1'b1;
    drain("idle", 100);

    // shape 0x0: decay then hold at 0
    for (int k = 1; k <= 18; k++)
      push("decay", (k < 16) ? 15 - k : 0, k >= 16,
           (k == 1) ? 5 : 4);
    wr(4'h0);
    @(negedge clk);
    chk("decay_start", 8'(bus.level), 8'd15);
    chk("decay_start_hold", 8'(bus.holding), 8'd0);
    drain("decay", 200);

    // shape 0xD, EP=2: attack and hold at 15
    bus.period = 16'd2;
    for (int k = 1; k <= 17; k++)
      push("attack_hold", (k < 16) ? k : 15, k >= 16,
           (k == 1) ? 9 : 8);
    wr(4'hd);
    @(negedge clk);
    chk("attack_start", 8'(bus.level), 8'd0);
    drain("attack_hold", 300);

    // shape 0xE: triangle, endpoints repeat
    bus.period = 16'd1;
    for (int k = 1; k <= 100; k++)
      push("triangle",
           ((k / 16) % 2 == 0) ? k % 16 : 15 - (k % 16), 0,
           (k == 1) ? 5 : 4);
    wr(4'he);
    drain("triangle", 1000);

    // shape 0x8: EP=0 behaves as EP=1
    bus.period = 16'd0;
    for (int k = 1; k <= 4; k++)
      push("saw_ep0", 15 - k, 0, (k == 1) ? 5 : 4);
    wr(4'h8);
    drain("saw_ep0", 100);
    bus.period = 16'd1;
    for (int k = 1; k <= 4; k++)
      push("saw_ep1", 15 - k, 0, (k == 1) ? 5 : 4);
    wr(4'h8);
    drain("saw_ep1", 100);

    // ce every other clock doubles the spacing
    ce_half = 1'b1;
    for (int k = 1; k <= 3; k++)
      push("saw_halfce", 15 - k, 0, (k == 1) ? -1 : 8);
    wr(4'h8);
    drain("saw_halfce", 200);
    ce_half = 1'b0;

    // period 100 -> 3 while pcnt=50
    bus.period = 16'd100;
    push("shrink", 14, 0, 205);
    push("shrink", 13, 0, 12);
    push("shrink", 12, 0, 12);
    wr(4'h8);
    repeat (201) @(posedge clk);
    #1;
    bus.period = 16'd3;
    drain("shrink", 400);

    // restart coincident with step event at cnt=7
    bus.period = 16'd1;
    for (int k = 1; k <= 7; k++)
      push("pre_restart", 15 - k, 0, (k == 1) ? 5 : 4);
    wr(4'h8);
    repeat (31) @(posedge clk);
    #1;
    push("post_restart", 1, 0, 5);
    push("post_restart", 2, 0, 4);
    bus.shape    = 4'hc;
    bus.shape_wr = 1'b1;
    @(posedge clk);
    #1;
    bus.shape_wr = 1'b0;
    @(negedge clk);
    chk("restart_step", 8'(bus.step), 8'd0);
    chk("restart_level", 8'(bus.level), 8'd0);
    chk("restart_hold", 8'(bus.holding), 8'd0);
    drain("post_restart", 100);

    // async reset mid-ramp, no clock edge needed
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 8'(bus.level), 8'd0);
    chk("arst_holding", 8'(bus.holding), 8'd1);
    chk("arst_step", 8'(bus.step), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("held_level", 8'(bus.level), 8'd0);
    chk("held_holding", 8'(bus.holding), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
